sram_port_ctrl: RTL
===================

# sram_port_ctrl

Parametrised multi-cycle memory port between the SLC-3 datapath's MAR/MDR and an external asynchronous SRAM. It replaces fixed-timing memory access with a valid/ready request and response handshake, a configurable wait-state count, and configurable address and data widths. One I/O address is decoded internally: reads return the board switches and writes update a hex-display register. The block also sequences the active-low SRAM strobes and the tristate drive enable.

## Interface
Parameters:
- DATA_W, 16, data width of CPU and SRAM words
- ADDR_W, 16, CPU address width
- SRAM_ADDR_W, 20, SRAM address width (must be ≥ ADDR_W; upper bits zero)
- WAIT_STATES, 2, cycles the strobes are held per SRAM access (legal range 1..15)
- IO_ADDR, all-ones of ADDR_W, memory-mapped switch/hex address

Ports:
- Clk  in  1  clock; the only clock
- Reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address (MAR)
- req_wdata  in  DATA_W  write data (MDR)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; valid while rsp_valid is high; holds its value afterwards
- Switches  in  DATA_W  board switches
- hex_out  out  DATA_W  hex-display register
- sram_addr  out  SRAM_ADDR_W  SRAM address
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes
- sram_wdata  out  DATA_W  data toward the tristate buffer
- sram_rdata  in  DATA_W  data from the tristate buffer
- sram_drive  out  1  tristate output enable (1 = drive the bus)
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACCESS, RECOVER, DONE.
- **IDLE**
  - req_ready=1 and all strobes are inactive (high).
  - On req_valid at an edge, the block latches addr, we and wdata.
  - If addr==IO_ADDR, the next state is DONE:
    - read: rsp_rdata ← Switches, sampled at the accept edge;
    - write: hex_out ← wdata at the accept edge.
  - Otherwise the next state is ACCESS and the wait counter ← WAIT_STATES.
- **ACCESS**
  - sram_ce_n=0, ub_n=lb_n=0.
  - Read: oe_n=0, we_n=1, drive=0.
  - Write: oe_n=1, we_n=0, drive=1.
  - The counter decrements every edge.
  - At the edge where counter==1: a read captures sram_rdata into rsp_rdata and goes to DONE; a write goes to RECOVER.
- **RECOVER** (writes only)
  - we_n=1, ce_n=0, ub_n=lb_n=0, drive=1, sram_wdata held.
  - This gives data hold time past the WE rising edge. Next state is DONE.
- **DONE**
  - rsp_valid=1, req_ready=0, all strobes inactive, drive=0. Next state is IDLE.
- sram_addr = latched addr zero-extended to SRAM_ADDR_W. It is stable from ACCESS through RECOVER and holds its value in IDLE/DONE.
- sram_wdata = latched wdata, stable for the whole transaction.
- req_valid is ignored outside IDLE. The requester must hold its request until req_ready is seen.
- IO_ADDR never generates an SRAM strobe.

## Timing
- Accept edge = edge 0.
- Read latency: ACCESS occupies cycles 1..WAIT_STATES; rsp_valid is high in cycle WAIT_STATES+1.
- Write latency: RECOVER is cycle WAIT_STATES+1; rsp_valid is high in cycle WAIT_STATES+2.
- I/O access: rsp_valid is high in cycle 1.
- Back-to-back: the next request can be accepted one cycle after DONE, in IDLE. Minimum request spacing is WAIT_STATES+2 cycles (read) and WAIT_STATES+3 cycles (write).
- Reset, including mid-transaction, takes effect at the next edge:
  - state=IDLE;
  - ce_n=oe_n=we_n=ub_n=lb_n=1, drive=0;
  - rsp_valid=0, rsp_rdata=0, hex_out=0, sram_addr=0, sram_wdata=0;
  - busy=0;
  - req_ready=0 while Reset is high, 1 in the first cycle after it falls.
- The interrupted SRAM access is abandoned, and no response is issued for it.

## Test plan
- Defaults, reset then read 0x0030 with the SRAM model returning 0x1234: oe_n low for exactly 2 cycles; rsp_valid in cycle 3; rsp_rdata=0x1234; sram_addr=0x00030.
- Write 0xBEEF to 0x0100: we_n low for 2 cycles, drive high for 3 cycles; rsp_valid in cycle 4; a following read of 0x0100 returns 0xBEEF.
- Write 0x00A5 to 0xFFFF: no strobe activity; hex_out=0x00A5 after the accept edge; rsp_valid in cycle 1. Then read 0xFFFF with Switches=0x5A5A: rsp_rdata=0x5A5A in cycle 1.
- WAIT_STATES=1 and WAIT_STATES=15: read strobe width is 1 and 15 cycles; rsp_valid in cycles 2 and 16.
- Assert Reset during the second ACCESS cycle of a write: all strobes high and drive=0 at the next edge; no rsp_valid; hex_out=0; req_ready=1 one cycle after Reset is released.
- Hold req_valid high continuously with alternating reads and writes: exactly one accept per transaction; requests are never accepted outside IDLE; busy is low only in IDLE.

Source files
------------

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl
//   Multi-cycle port between the CPU's MAR/MDR and an external asynchronous
//   SRAM, using a valid/ready request and a one-cycle response pulse. A
//   single memory-mapped I/O address (IO_ADDR) is served internally: reads
//   return the board switches and writes load the hex-display register.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | ready for a request, strobes inactive
//   ACCESS  | SRAM strobes asserted for WAIT_STATES cycles
//   RECOVER | write only: WE released, data and CE held for hold time
//   DONE    | o_rsp_valid pulse, strobes inactive
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_req_valid/o_req_ready   request handshake
//   i_req_we                  1 = write, 0 = read
//   i_req_addr, i_req_wdata   request address and write data
//   o_rsp_valid, o_rsp_rdata  completion pulse and read data (held)
//   i_switches, o_hex_out     I/O-mapped switches and hex-display register
//   o_sram_*                  SRAM address, active-low strobes, write data
//   i_sram_rdata              data from the tristate buffer
//   o_sram_drive              tristate output enable (1 = drive the bus)
//   o_busy                    high in every state except IDLE

module sram_port_ctrl #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                SRAM_ADDR_W = 20,
    parameter int                WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR     = '1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_we,
    input  logic [ADDR_W-1:0]      i_req_addr,
    input  logic [DATA_W-1:0]      i_req_wdata,
    output logic                   o_rsp_valid,
    output logic [DATA_W-1:0]      o_rsp_rdata,
    input  logic [DATA_W-1:0]      i_switches,
    output logic [DATA_W-1:0]      o_hex_out,
    output logic [SRAM_ADDR_W-1:0] o_sram_addr,
    output logic                   o_sram_ce_n,
    output logic                   o_sram_oe_n,
    output logic                   o_sram_we_n,
    output logic                   o_sram_ub_n,
    output logic                   o_sram_lb_n,
    output logic [DATA_W-1:0]      o_sram_wdata,
    input  logic [DATA_W-1:0]      i_sram_rdata,
    output logic                   o_sram_drive,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RECOVER = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t                 r_state;
    logic [3:0]             r_wait_cnt;
    logic                   r_we;
    logic                   r_rsp_valid;
    logic [DATA_W-1:0]      r_rsp_rdata;
    logic [DATA_W-1:0]      r_hex_out;
    logic [SRAM_ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0]      r_sram_wdata;
    logic                   r_ce_n;
    logic                   r_oe_n;
    logic                   r_we_n;
    logic                   r_bytes_n;
    logic                   r_drive;

    logic                   w_is_io;

    assign w_is_io = (i_req_addr == IO_ADDR);

    // Strobes are registered and set on the edge that enters each state, so
    // they line up exactly with the state they belong to.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= 4'd0;
            r_we         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_hex_out    <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_bytes_n    <= 1'b1;
            r_drive      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_we         <= i_req_we;
                        r_sram_addr  <= SRAM_ADDR_W'(i_req_addr);
                        r_sram_wdata <= i_req_wdata;
                        if (w_is_io) begin
                            // I/O access completes without touching the SRAM
                            if (i_req_we) begin
                                r_hex_out <= i_req_wdata;
                            end else begin
                                r_rsp_rdata <= i_switches;
                            end
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_wait_cnt <= WAIT_INIT;
                            r_ce_n     <= 1'b0;
                            r_bytes_n  <= 1'b0;
                            r_oe_n     <= i_req_we;
                            r_we_n     <= ~i_req_we;
                            r_drive    <= i_req_we;
                            r_state    <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    if (r_wait_cnt == 4'd1) begin
                        if (r_we) begin
                            // release WE first; CE and bus drive stay for hold time
                            r_we_n  <= 1'b1;
                            r_state <= S_RECOVER;
                        end else begin
                            r_rsp_rdata <= i_sram_rdata;
                            r_ce_n      <= 1'b1;
                            r_oe_n      <= 1'b1;
                            r_bytes_n   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_RECOVER: begin
                    r_ce_n      <= 1'b1;
                    r_bytes_n   <= 1'b1;
                    r_drive     <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Ready is held low for as long as reset is asserted.
    assign o_req_ready  = (r_state == S_IDLE) && !i_reset;
    assign o_busy       = (r_state != S_IDLE);
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_rdata  = r_rsp_rdata;
    assign o_hex_out    = r_hex_out;
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_wdata = r_sram_wdata;
    assign o_sram_ce_n  = r_ce_n;
    assign o_sram_oe_n  = r_oe_n;
    assign o_sram_we_n  = r_we_n;
    assign o_sram_ub_n  = r_bytes_n;
    assign o_sram_lb_n  = r_bytes_n;
    assign o_sram_drive = r_drive;

endmodule
